// File: rtl/chardisp_clk_pkg.sv
// chardisp_clk_pkg: shared types, BCD bounds and increment helper for the time-of-day counter
package chardisp_clk_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_t;
  typedef logic [7:0] bcd2_t;
  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_23 = 8'h23;
  localparam bcd2_t BCD_12 = 8'h12;
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD counter over MIN_VAL..MAX_VAL with load-to-minimum and wrap carry
module bcd_counter_2d
  import chardisp_clk_pkg::*;
#(
  parameter bcd2_t MIN_VAL = 8'h00,
  parameter bcd2_t MAX_VAL = 8'h59,
  parameter bcd2_t INIT    = 8'h00
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  load_i,
  output bcd2_t q_o,
  output logic  wrap_o
);
  bcd2_t q_q, q_d;
  always_comb q_d = load_i ? MIN_VAL : !en_i ? q_q : (q_q == MAX_VAL) ? MIN_VAL : bcd_inc(q_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= INIT;
    else q_q <= q_d;
  assign q_o    = q_q;
  assign wrap_o = en_i && (q_q == MAX_VAL);
endmodule

// File: rtl/digital_clock_counter.sv
// digital_clock_counter: BCD HH:MM:SS clock advanced by rising edges of a 1 Hz wave, with button set mode
module digital_clock_counter
  import chardisp_clk_pkg::*;
#(
  parameter bit    H24       = 1'b1,
  parameter bcd2_t INIT_HOUR = 8'h00,
  parameter bcd2_t INIT_MIN  = 8'h00
) (
  input  logic       PCK,
  input  logic       RST_N,
  input  logic       TICK_IN,
  input  logic       MODE_BTN,
  input  logic       INC_BTN,
  output logic [7:0] HOUR_BCD,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic [1:0] MODE,
  output logic       UPD
);
  localparam bcd2_t HR_MIN  = H24 ? 8'h00 : 8'h01;
  localparam bcd2_t HR_MAX  = H24 ? BCD_23 : BCD_12;
  localparam bcd2_t HR_INIT = (!H24 && INIT_HOUR == 8'h00) ? BCD_12 : INIT_HOUR;
  mode_t mode_q, mode_d;
  logic t1_q, t2_q, upd_q, upd_d;
  logic tick, sec_en, sec_load, sec_wrap, min_en, min_wrap, hr_en, unused_hr_wrap;
  always_comb begin
    tick     = t1_q && !t2_q;
    mode_d   = !MODE_BTN ? mode_q : (mode_q == RUN) ? SET_HR : (mode_q == SET_HR) ? SET_MIN : RUN;
    sec_en   = (mode_q == RUN) && tick && !MODE_BTN;
    sec_load = (mode_q == SET_MIN) && MODE_BTN;
    min_en   = sec_wrap || ((mode_q == SET_MIN) && INC_BTN && !MODE_BTN);
    // min_wrap only carries into hours while running; sec_wrap is zero in set modes
    hr_en    = (sec_wrap && min_wrap) || ((mode_q == SET_HR) && INC_BTN && !MODE_BTN);
    upd_d    = sec_en || min_en || hr_en || sec_load;
  end
  always_ff @(posedge PCK or negedge RST_N)
    if (!RST_N) begin
      t1_q   <= 1'b0;
      t2_q   <= 1'b0;
      mode_q <= RUN;
      upd_q  <= 1'b0;
    end else begin
      t1_q   <= TICK_IN;
      t2_q   <= t1_q;
      mode_q <= mode_d;
      upd_q  <= upd_d;
    end
  bcd_counter_2d #(.MIN_VAL(8'h00), .MAX_VAL(BCD_59), .INIT(8'h00)) u_sec (
    .clk_i(PCK), .rst_ni(RST_N), .en_i(sec_en), .load_i(sec_load), .q_o(SEC_BCD), .wrap_o(sec_wrap)
  );
  bcd_counter_2d #(.MIN_VAL(8'h00), .MAX_VAL(BCD_59), .INIT(INIT_MIN)) u_min (
    .clk_i(PCK), .rst_ni(RST_N), .en_i(min_en), .load_i(1'b0), .q_o(MIN_BCD), .wrap_o(min_wrap)
  );
  bcd_counter_2d #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .INIT(HR_INIT)) u_hr (
    .clk_i(PCK), .rst_ni(RST_N), .en_i(hr_en), .load_i(1'b0), .q_o(HOUR_BCD), .wrap_o(unused_hr_wrap)
  );
  assign MODE = mode_q;
  assign UPD  = upd_q;
endmodule

// File: tb/tb_digital_clock_counter.sv
// tb_digital_clock_counter: directed checks of ticking, rollover, set mode and event priority
`timescale 1ns/1ps
module tb_digital_clock_counter;
  logic PCK = 1'b0, RST_N = 1'b0, TICK_IN = 1'b0, MODE_BTN = 1'b0, INC_BTN = 1'b0;
  logic [7:0] h0, m0, s0, h1, m1, s1, h2, m2, s2;
  logic [1:0] md0, md1, md2;
  logic up0, up1, up2;
  int n_chk = 0, n_fail = 0;
  always #5 PCK = ~PCK;
  digital_clock_counter u0 (
    .PCK(PCK), .RST_N(RST_N), .TICK_IN(TICK_IN), .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN),
    .HOUR_BCD(h0), .MIN_BCD(m0), .SEC_BCD(s0), .MODE(md0), .UPD(up0)
  );
  digital_clock_counter #(.H24(1'b1), .INIT_HOUR(8'h23), .INIT_MIN(8'h59)) u1 (
    .PCK(PCK), .RST_N(RST_N), .TICK_IN(TICK_IN), .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN),
    .HOUR_BCD(h1), .MIN_BCD(m1), .SEC_BCD(s1), .MODE(md1), .UPD(up1)
  );
  digital_clock_counter #(.H24(1'b0), .INIT_HOUR(8'h12), .INIT_MIN(8'h59)) u2 (
    .PCK(PCK), .RST_N(RST_N), .TICK_IN(TICK_IN), .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN),
    .HOUR_BCD(h2), .MIN_BCD(m2), .SEC_BCD(s2), .MODE(md2), .UPD(up2)
  );
  task automatic step(input int n);
    repeat (n) @(posedge PCK);
    #1;
  endtask
  task automatic do_reset;
    RST_N = 1'b0; TICK_IN = 1'b0; MODE_BTN = 1'b0; INC_BTN = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(1);
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      TICK_IN = 1'b1; step(3);
      TICK_IN = 1'b0; step(3);
    end
  endtask
  task automatic mode_press;
    MODE_BTN = 1'b1; step(1); MODE_BTN = 1'b0;
  endtask
  task automatic inc_press;
    INC_BTN = 1'b1; step(1); INC_BTN = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    n_chk++; if ({h0, m0, s0} !== 24'h000000) begin n_fail++; $display("FAIL reset_time: got %h want 000000", {h0, m0, s0}); end
    n_chk++; if ({md0, up0} !== 3'b000) begin n_fail++; $display("FAIL reset_mode_upd: got %b want 000", {md0, up0}); end
    n_chk++; if ({h1, m1, s1} !== 24'h235900) begin n_fail++; $display("FAIL reset_init: got %h want 235900", {h1, m1, s1}); end
    n_chk++; if (h2 !== 8'h12) begin n_fail++; $display("FAIL reset_h12: got %h want 12", h2); end
    tick_n(37);
    n_chk++; if ({h0, m0, s0} !== 24'h000037) begin n_fail++; $display("FAIL count37: got %h want 000037", {h0, m0, s0}); end
    RST_N = 1'b0;
    #1;
    n_chk++; if ({h0, m0, s0, md0, up0} !== 27'h0) begin n_fail++; $display("FAIL async_reset: got %h want 0", {h0, m0, s0, md0, up0}); end
    step(1);
    RST_N = 1'b1;
  endtask
  task automatic test_tick;
    do_reset;
    for (int i = 1; i <= 3; i++) begin
      TICK_IN = 1'b1; step(1);
      n_chk++; if ({s0, up0} !== {8'(i - 1), 1'b0}) begin n_fail++; $display("FAIL tick_early%0d: got %h/%b want %h/0", i, s0, up0, 8'(i - 1)); end
      step(1);
      n_chk++; if ({s0, up0} !== {8'(i), 1'b1}) begin n_fail++; $display("FAIL tick_step%0d: got %h/%b want %h/1", i, s0, up0, 8'(i)); end
      step(1);
      n_chk++; if ({s0, up0} !== {8'(i), 1'b0}) begin n_fail++; $display("FAIL tick_hold%0d: got %h/%b want %h/0", i, s0, up0, 8'(i)); end
      TICK_IN = 1'b0; step(3);
      n_chk++; if ({s0, up0} !== {8'(i), 1'b0}) begin n_fail++; $display("FAIL tick_fall%0d: got %h/%b want %h/0", i, s0, up0, 8'(i)); end
    end
  endtask
  task automatic test_rollover;
    do_reset;
    tick_n(59);
    n_chk++; if ({h1, m1, s1} !== 24'h235959) begin n_fail++; $display("FAIL pre_roll24: got %h want 235959", {h1, m1, s1}); end
    n_chk++; if ({h2, m2, s2} !== 24'h125959) begin n_fail++; $display("FAIL pre_roll12: got %h want 125959", {h2, m2, s2}); end
    TICK_IN = 1'b1; step(2);
    n_chk++; if ({h1, m1, s1, up1} !== {24'h000000, 1'b1}) begin n_fail++; $display("FAIL roll24: got %h/%b want 000000/1", {h1, m1, s1}, up1); end
    n_chk++; if ({h2, m2, s2} !== 24'h010000) begin n_fail++; $display("FAIL roll12: got %h want 010000", {h2, m2, s2}); end
    TICK_IN = 1'b0; step(3);
  endtask
  task automatic test_set;
    logic [7:0] exp_h [3];
    exp_h = '{8'h23, 8'h00, 8'h01};
    do_reset;
    tick_n(2);
    inc_press;
    n_chk++; if ({h0, up0} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL inc_in_run: got %h/%b want 00/0", h0, up0); end
    mode_press;
    n_chk++; if ({md0, h0, up0} !== {2'd1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL enter_set_hr: got %h/%h/%b want 1/00/0", md0, h0, up0); end
    repeat (22) inc_press;
    n_chk++; if (h0 !== 8'h22) begin n_fail++; $display("FAIL set_hr22: got %h want 22", h0); end
    for (int i = 0; i < 3; i++) begin
      inc_press;
      n_chk++; if ({h0, up0} !== {exp_h[i], 1'b1}) begin n_fail++; $display("FAIL set_hr_step%0d: got %h/%b want %h/1", i, h0, up0, exp_h[i]); end
    end
    n_chk++; if (h2 !== 8'h01) begin n_fail++; $display("FAIL set_hr12_wrap: got %h want 01", h2); end
    TICK_IN = 1'b1; step(3); TICK_IN = 1'b0; step(3);
    n_chk++; if ({m0, s0, up0} !== {16'h0002, 1'b0}) begin n_fail++; $display("FAIL tick_in_set: got %h/%b want 0002/0", {m0, s0}, up0); end
    mode_press;
    n_chk++; if (md0 !== 2'd2) begin n_fail++; $display("FAIL enter_set_min: got %h want 2", md0); end
    inc_press;
    n_chk++; if ({h1, m1} !== 16'h0000) begin n_fail++; $display("FAIL set_min_wrap: got %h want 0000", {h1, m1}); end
    n_chk++; if ({h0, m0, up0} !== {16'h0101, 1'b1}) begin n_fail++; $display("FAIL set_min_inc: got %h/%b want 0101/1", {h0, m0}, up0); end
    TICK_IN = 1'b1; step(3); TICK_IN = 1'b0; step(3);
    n_chk++; if (s0 !== 8'h02) begin n_fail++; $display("FAIL tick_in_set_min: got %h want 02", s0); end
  endtask
  task automatic test_exit;
    do_reset;
    tick_n(42);
    mode_press;
    mode_press;
    n_chk++; if ({md0, s0} !== {2'd2, 8'h42}) begin n_fail++; $display("FAIL set_min_hold: got %h/%h want 2/42", md0, s0); end
    mode_press;
    n_chk++; if ({md0, s0, up0} !== {2'd0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL exit_clear: got %h/%h/%b want 0/00/1", md0, s0, up0); end
    step(1);
    n_chk++; if (up0 !== 1'b0) begin n_fail++; $display("FAIL exit_upd_once: got %b want 0", up0); end
  endtask
  task automatic test_simul;
    do_reset;
    tick_n(1);
    MODE_BTN = 1'b1; INC_BTN = 1'b1; step(1); MODE_BTN = 1'b0; INC_BTN = 1'b0;
    n_chk++; if ({md0, h0, up0} !== {2'd1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL mode_over_inc: got %h/%h/%b want 1/00/0", md0, h0, up0); end
    mode_press;
    TICK_IN = 1'b1; step(1);
    MODE_BTN = 1'b1; step(1); MODE_BTN = 1'b0;
    n_chk++; if ({md0, s0, up0} !== {2'd0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL tick_at_exit: got %h/%h/%b want 0/00/1", md0, s0, up0); end
    TICK_IN = 1'b0; step(3);
    tick_n(1);
    TICK_IN = 1'b1; step(1);
    MODE_BTN = 1'b1; step(1); MODE_BTN = 1'b0;
    n_chk++; if ({md0, s0, up0} !== {2'd1, 8'h01, 1'b0}) begin n_fail++; $display("FAIL tick_at_enter: got %h/%h/%b want 1/01/0", md0, s0, up0); end
    TICK_IN = 1'b0; step(3);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_tick;
    test_rollover;
    test_set;
    test_exit;
    test_simul;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
